// File: rtl/afifo_rd_stage.sv
// Read-domain consumer for the async FIFO pop side: show-ahead head -> registered
// valid/ready stream via a 2-entry skid buffer, with flush/drain and a delivered-word counter.
//
// state | meaning
// RUN   | normal streaming, buffer fills from the FIFO head
// FLUSH | buffer emptied, FIFO drained and discarded until empty with flush low
module afifo_rd_stage #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [W-1:0]     fifo_data,
  output logic             fifo_pop,
  output logic             out_vld,
  output logic [W-1:0]     out_data,
  input  logic             out_rdy,
  input  logic             flush,
  output logic             flush_busy,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] deliv_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t     state, state_n;
  logic [W-1:0] head, skid, head_n, skid_n;
  logic [1:0] occ_n;
  logic       pop_int;
  logic       xfer;

  assign xfer       = out_vld & out_rdy;
  assign out_data   = head;
  assign flush_busy = (state == FLUSH);
  // Keep the FIFO pointer still while reset is held.
  assign fifo_pop   = pop_int & rst_n;

  always_comb begin
    state_n = state;
    pop_int = 1'b0;
    occ_n   = occ;
    head_n  = head;
    skid_n  = skid;
    case (state)
      RUN: begin
        if (flush) begin
          state_n = FLUSH;
          pop_int = ~fifo_empty;
          occ_n   = 2'd0;
        end else begin
          pop_int = ~fifo_empty & ((occ < 2'd2) | xfer);
          occ_n   = occ + {1'b0, pop_int} - {1'b0, xfer};
          if (pop_int) begin
            if ((occ == 2'd0) || ((occ == 2'd1) && xfer)) begin
              head_n = fifo_data;
            end else if (occ == 2'd1) begin
              skid_n = fifo_data;
            end else begin
              head_n = skid;
              skid_n = fifo_data;
            end
          end else if (xfer && (occ == 2'd2)) begin
            head_n = skid;
          end
        end
      end
      FLUSH: begin
        pop_int = ~fifo_empty;
        occ_n   = 2'd0;
        if (fifo_empty && !flush) state_n = RUN;
      end
      default: begin
        state_n = RUN;
        occ_n   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      occ     <= 2'd0;
      out_vld <= 1'b0;
      head    <= '0;
      skid    <= '0;
    end else begin
      state   <= state_n;
      occ     <= occ_n;
      out_vld <= (occ_n != 2'd0);
      head    <= head_n;
      skid    <= skid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deliv_cnt <= '0;
    end else if (xfer && (deliv_cnt != {CNT_W{1'b1}})) begin
      deliv_cnt <= deliv_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/afifo_rd_stage.md
Name: afifo_rd_stage

Overview:
- Read-domain consumer stage placed directly downstream of the async FIFO's pop side.
- Converts the FIFO's show-ahead head interface (empty / pop / head data) into a registered valid/ready stream through a 2-entry skid buffer.
- Adds a flush sequence that drains and discards FIFO contents, plus a saturating delivered-word counter.
- All logic runs in the FIFO's read clock domain.

Parameters:
- W, 32, data word width; must equal the FIFO's W.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  input  1  read-domain clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- fifo_empty  input  1  FIFO has no head word this cycle; must not depend combinationally on fifo_pop.
- fifo_data  input  W  FIFO head word; valid whenever fifo_empty=0.
- fifo_pop  output  1  consume head word; pointer advances at next clk edge.
- out_vld  output  1  output word valid (registered).
- out_data  output  W  output word (registered).
- out_rdy  input  1  downstream accepts out_data this cycle.
- flush  input  1  request discard of buffered and FIFO-resident data.
- flush_busy  output  1  flush in progress (FSM in FLUSH).
- occ  output  2  buffer occupancy, 0..2.
- deliv_cnt  output  CNT_W  count of accepted output words.

Behaviour:
- Reset (rst_n=0, async): FSM=RUN, occ=0, out_vld=0, out_data=0, flush_busy=0, deliv_cnt=0. fifo_pop=0 while in reset.
- Buffer: two registers, head (drives out_data) and skid.
- out_vld = (occ != 0); out_data = head.
- Transfer: xfer = out_vld & out_rdy. out_vld, once high, stays high and out_data stays stable until xfer.
- fifo_pop in RUN, no flush: fifo_pop = ~fifo_empty & ((occ < 2) | xfer).
- Latency: a word at the FIFO head in cycle t with occ=0 appears on out_vld/out_data in cycle t+1. Throughput is 1 word/cycle under continuous out_rdy.
- Write placement at each edge with fifo_pop=1 (fifo_data captured):
  - occ=0: load head.
  - occ=1 with xfer: load head.
  - occ=1 without xfer: load skid.
  - occ=2 with xfer: head<=skid, skid<=fifo_data.
- Edges with fifo_pop=0 and xfer: head<=skid when occ=2.
- occ_next = occ + fifo_pop - xfer. occ never exceeds 2 and never underflows.
- Ordering: words leave in strict FIFO order; none duplicated or dropped outside flush.
- FSM state RUN:
  - flush=1 -> FLUSH next edge.
  - At that edge, occ<=0 (all buffered words discarded). An xfer in the same cycle still completes and counts.
  - fifo_pop in that cycle = ~fifo_empty; the popped word is discarded.
- FSM state FLUSH:
  - flush_busy=1, out_vld=0 (occ held at 0), fifo_pop = ~fifo_empty, popped data discarded.
  - Exit to RUN when fifo_empty=1 and flush=0 in the same cycle.
  - Holding flush=1 keeps the block in FLUSH and continues draining.
- deliv_cnt: +1 on each xfer, saturates at 2^CNT_W-1 (no wrap), cleared only by reset.
- Reset mid-operation: immediate return to reset values. Buffered data is lost; FIFO contents are not popped.
- out_rdy while out_vld=0 has no effect.

Test Plan:
- Streaming: push 0x10..0x17 into the FIFO, out_rdy=1 constant -> out_data 0x10..0x17 on 8 consecutive cycles, first word 1 cycle after fifo_empty falls; deliv_cnt=8.
- Backpressure: 4 words queued, out_rdy=0 for 5 cycles -> occ=2, fifo_pop=0 after 2 pops, out_data held at word0. Then out_rdy=1 -> words 0..3 in order with no gap or duplicate.
- Random out_rdy (50%) over 1000 words with random FIFO refill -> scoreboard exact order match; occ<=2 always.
- Flush: 6 words queued, occ=2, out_rdy=0; pulse flush 1 cycle -> flush_busy=1, out_vld=0, 4 FIFO pops discarded, return to RUN once fifo_empty. A word pushed after that emerges normally; deliv_cnt unchanged.
- Flush with simultaneous xfer: occ=1, out_rdy=1, flush=1 in the same cycle -> that word counts (deliv_cnt+1), nothing else emitted.
- Saturation/reset: CNT_W=4, deliver 20 words -> deliv_cnt=15. Assert rst_n=0 mid-stream -> out_vld=0, occ=0, deliv_cnt=0 immediately, with no clk edge required.
